sm_dmem_arbiter: RTL

//  Shares one single-port synchronous data RAM between the CPU load/store path (lw/sw)
//  and the board debug read port (ramAddr/ramData). Sits between sm_cpu and the data RAM.
//  CPU has priority; debug is guaranteed service after a bounded wait. Drives a CPU stall.

---
 rtl/sm_dmem_pkg.sv | 15 +
 rtl/sm_dmem_wait_counter.sv | 30 +++
 rtl/sm_dmem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sm_dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and counter sizing.
package sm_dmem_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_CPU  = 2'd1,
        DMA_DBG  = 2'd2
    } dma_state_t;

    // Bits needed to hold 0..max inclusive; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sm_dmem_wait_counter.sv
// Saturating up-counter tracking how long a pending debug request has lost arbitration.
module sm_dmem_wait_counter
    import sm_dmem_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [W-1:0] count;

    assign sat = (count == W'(MAX));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sm_dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU load/store path and the
// debug read port. CPU wins ties unless debug has already lost DBG_STARVE_MAX times.
module sm_dmem_arbiter
    import sm_dmem_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 32,
    parameter int DBG_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dma_state_t        state, state_nxt;
    logic              cpu_elig, dbg_elig;
    logic              grant_cpu, grant_dbg;
    logic              wait_sat;
    logic              cpu_load_q;
    logic [DATA_W-1:0] cpu_hold, dbg_hold;

    assign cpu_ack   = (state == DMA_CPU);
    assign dbg_ack   = (state == DMA_DBG);
    assign cpu_stall = cpu_req & ~cpu_ack;

    // A request seen in its own ack cycle is the one just served, not a new one.
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign dbg_elig = dbg_req & ~dbg_ack;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        state_nxt = DMA_IDLE;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Nothing reaches the RAM while reset is held, even with requests pending.
        if (rst_n) begin
            if (cpu_elig && dbg_elig) begin
                grant_dbg = wait_sat;
                grant_cpu = ~wait_sat;
            end else begin
                grant_cpu = cpu_elig;
                grant_dbg = dbg_elig;
            end
        end

        if (grant_cpu) begin
            state_nxt = DMA_CPU;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dbg) begin
            state_nxt = DMA_DBG;
            mem_en    = 1'b1;
            mem_addr  = dbg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DMA_IDLE;
            cpu_load_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_cpu) begin
                cpu_load_q <= ~cpu_we;
            end
        end
    end

    // NOTE: the hold registers are reset so outputs start at zero; the RAM itself is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (cpu_ack && cpu_load_q) begin
                cpu_hold <= mem_rdata;
            end
            if (dbg_ack) begin
                dbg_hold <= mem_rdata;
            end
        end
    end

    // Read data is passed straight through in the ack cycle, then held.
    assign cpu_rdata = (cpu_ack && cpu_load_q) ? mem_rdata : cpu_hold;
    assign dbg_rdata = dbg_ack ? mem_rdata : dbg_hold;

    sm_dmem_wait_counter #(
        .MAX (DBG_STARVE_MAX)
    ) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dbg_elig & ~grant_dbg),
        .clr   (grant_dbg | ~dbg_req),
        .sat   (wait_sat)
    );

endmodule
